// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed hex display: the active-low segment
// table (bit 0 = segment a) and the all-off pattern.
package hex_display_pkg;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [0:6] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low seven-segment pattern (index 0 = a).
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [0:6] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver with leading-zero blanking and blink.
// One digit is shown per scan tick; segment and anode outputs are registered.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [0:6]              leds,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        r_tick_cnt;
  logic [BLK_W-1:0]        r_blink_cnt;
  logic                    r_blink_phase;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [0:6]              r_leds;
  logic [NUM_DIGITS-1:0]   r_digit_sel;

  logic                    w_tick;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_nz;
  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [0:6]              w_seg;
  logic                    w_blank;

  assign w_tick = (r_tick_cnt == CNT_W'(SCAN_DIV - 1));

  // w_nz[k] is set when any nibble at position k or above is non-zero;
  // digit 0 always stays visible so a zero value still shows "0".
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
    assign w_nib[k] = r_value[4*k +: 4];
    if (k == NUM_DIGITS - 1) begin : g_top
      assign w_nz[k] = |w_nib[k];
    end else begin : g_rest
      assign w_nz[k] = w_nz[k+1] | (|w_nib[k]);
    end
    if (k == 0) begin : g_lsd
      assign w_lz_mask[k] = 1'b0;
    end else begin : g_upper
      assign w_lz_mask[k] = ~w_nz[k];
    end
  end

  hex_seg_decode u_decode (
    .i_nibble (w_nib[r_idx]),
    .o_seg    (w_seg)
  );

  assign w_blank = (blink_en & r_blink_phase) | (blank_lz & w_lz_mask[r_idx]);

  // NOTE: every register here uses non-blocking assignment so all state
  // updates on an edge see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_idx         <= '0;
      r_value       <= '0;
      r_leds        <= SEG_BLANK;
      r_digit_sel   <= '1;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);

      if (w_tick) begin
        r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
      end

      if (load) begin
        r_value <= value;
      end

      // Outputs follow the pre-edge index/value, one cycle behind them.
      r_leds      <= w_blank ? SEG_BLANK : w_seg;
      r_digit_sel <= w_blank ? '1 : ~(NUM_DIGITS'(1) << r_idx);
    end
  end

  assign leds      = r_leds;
  assign digit_sel = r_digit_sel;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench: directed scenarios plus random stimulus, compared
// against a cycle-count based reference model of the display.
module tb_hex_display_scanner;

  localparam int N = 4;
  localparam int S = 4;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        blink_en;
  logic [0:6]  leds;
  logic [3:0]  digit_sel;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          c;          // rising edges seen since reset release
  logic [15:0] mval;       // model of the captured value
  int          last_idx;   // digit the latest expected output refers to

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (S),
    .BLINK_DIV  (B)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .value     (value),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .leds      (leds),
    .digit_sel (digit_sel)
  );

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0000100;
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: inputs set on the falling edge, outputs sampled 1 time unit
  // after the rising edge. The shown digit depends on how many full scan
  // intervals have elapsed before this edge.
  task automatic step(input logic ld, input logic [15:0] v,
                      input logic blz, input logic ben);
    int          tk;
    int          idx;
    int          ph;
    logic [15:0] hi;
    logic        blk;
    logic [6:0]  exp_leds;
    logic [3:0]  exp_sel;
    @(negedge clk);
    load = ld; value = v; blank_lz = blz; blink_en = ben;
    tk  = c / S;
    idx = tk % N;
    ph  = (tk / B) % 2;
    hi  = mval >> (4 * idx);
    blk = (ben && ph == 1) || (blz && idx != 0 && hi == 16'h0);
    exp_leds = blk ? 7'h7F : ref_seg(int'(hi[3:0]));
    exp_sel  = blk ? 4'hF : (4'hF ^ (4'b0001 << idx));
    @(posedge clk);
    #1;
    if (ld) mval = v;
    c++;
    last_idx = idx;
    check("leds", {1'b0, leds}, {1'b0, exp_leds});
    check("digit_sel", {4'b0, digit_sel}, {4'b0, exp_sel});
  endtask

  initial begin
    resetn = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0; blink_en = 1'b0;
    c = 0; mval = '0; last_idx = 0;

    // Asynchronous reset with no clock edge, then held across edges.
    #3 resetn = 1'b0;
    #1;
    check("rst_leds_async", {1'b0, leds}, 8'h7F);
    check("rst_sel_async", {4'b0, digit_sel}, 8'h0F);
    repeat (2) @(posedge clk);
    #1;
    check("rst_leds_held", {1'b0, leds}, 8'h7F);
    check("rst_sel_held", {4'b0, digit_sel}, 8'h0F);
    #1 resetn = 1'b1;

    // Plain scan of 12AF, no blanking.
    step(1'b1, 16'h12AF, 1'b0, 1'b0);
    repeat (2 * N * S) step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Leading-zero blanking of 0030, then of 0.
    step(1'b1, 16'h0030, 1'b1, 1'b0);
    repeat (N * S) step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 1'b1, 1'b0);
    repeat (N * S) step(1'b0, 16'hFFFF, 1'b1, 1'b0);

    // Blinking: lit for B ticks, dark for B ticks.
    step(1'b1, 16'h12AF, 1'b0, 1'b1);
    repeat (4 * S * B) step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Load coinciding with a scan tick.
    step(1'b1, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < S && (c % S) != S - 1; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("load_on_tick_leds", {1'b0, leds}, 8'b00100100);

    // Reset in the middle of digit 2.
    step(1'b1, 16'h9876, 1'b0, 1'b0);
    for (int i = 0; i < 2 * N * S && last_idx != 2; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("mid_digit2_sel", {4'b0, digit_sel}, 8'b00001011);
    #2 resetn = 1'b0;
    #1;
    check("midscan_rst_leds", {1'b0, leds}, 8'h7F);
    check("midscan_rst_sel", {4'b0, digit_sel}, 8'h0F);
    @(posedge clk);
    #1 resetn = 1'b1;
    c = 0; mval = '0;
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("restart_digit0_sel", {4'b0, digit_sel}, 8'b00001110);
    repeat (N * S + 1) step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Random traffic, including values with leading zeros.
    for (int i = 0; i < 400; i++) begin
      logic        ld;
      logic [15:0] v;
      ld = ($urandom_range(0, 7) == 0);
      v  = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
      step(ld, v, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
